mix_columns_engine: RTL and testbench
=====================================

# mix_columns_engine

Parametrised, handshaked MixColumns engine for the AES datapath. It accepts one 128-bit state, processes `COLS_PER_CYCLE` columns per clock through replicated column units, and returns the result on a registered output. It supports forward MixColumns, InvMixColumns for the decryption path, and a bypass mode for the final round. It sits between ShiftRows and AddRoundKey in the round pipeline and replaces the purely combinational column mixer.

## Interface
- `COLS_PER_CYCLE`, default 4: columns processed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `in_valid` input, 1 bit: `in_data`, `inv` and `bypass` are valid.
- `in_ready` output, 1 bit: engine can accept a state.
- `in_data` input, 128 bits: input state. Column c is `[c*32 +: 32]`. Within a column, row 0 is `[c*32+24 +: 8]`, row 1 `+16`, row 2 `+8`, row 3 `+0`.
- `inv` input, 1 bit: 1 selects InvMixColumns.
- `bypass` input, 1 bit: 1 passes the state through unchanged.
- `out_valid` output, 1 bit: `out_data` holds a result.
- `out_ready` input, 1 bit: downstream accepts the result.
- `out_data` output, 128 bits: result state, same byte layout as `in_data`.

## Operation
- FSM states are IDLE, BUSY and DONE. `in_ready = (state == IDLE)`. `out_valid = (state == DONE)`.
- **IDLE:**
  - When `in_valid && in_ready`, capture `in_data` into the working register.
  - Capture `inv` and `bypass` into mode flags.
  - Clear the group counter and go to BUSY.
  - `inv` and `bypass` are sampled only at capture. They are ignored at all other times.
- **BUSY:**
  - Each cycle, group g (g = 0 … N-1, where N = 4/COLS_PER_CYCLE) processes column indices 3-g·C down to 4-(g+1)·C, with C = COLS_PER_CYCLE. This order is highest word first.
  - Results are written back into the working register in place.
  - At g = N-1, go to DONE.
- **DONE:** `out_data` is the working register. It stays stable until `out_valid && out_ready`, then the FSM returns to IDLE.
- **Forward arithmetic** (a0…a3 = rows of one column, all arithmetic in GF(2^8), poly 0x11B, xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0)):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- **Inverse arithmetic:** uses the matrix rows {0E,0B,0D,09}, rotated per row. Multiplications are built from chained xtime; no lookup tables.
- **Bypass:** the column unit output equals its input. The FSM still walks all groups, so latency is identical to the other modes.
- `bypass` takes priority over `inv`.

## Timing
- **Reset values:** state IDLE, group counter 0, working register 0, mode flags 0. Therefore `in_ready` = 1, `out_valid` = 0, `out_data` = 0.
- **Reset mid-operation:** any in-flight or unaccepted result is discarded with no output. The engine is in IDLE the cycle after `rst` is deasserted.
- **Latency:**
  - Capture at edge E0; groups are written at edges E1…EN.
  - `out_valid` is high from the cycle after EN.
  - For C=4, N=1: the result is visible one cycle after capture.
- **Throughput:** one state per N+2 cycles when `out_ready` is held high. There is no accept-while-DONE overlap.
- **Backpressure:** `out_data` and `out_valid` hold indefinitely while `out_ready` = 0. `in_ready` stays 0 until the result is accepted.
- **Input side:** `in_valid` may assert while `in_ready` = 0. The producer holds its data; nothing is captured.

## Configuration
- Macro: `AES_MIX_COLUMNS_INV_EN`.
- **Defined:** the inverse matrix logic is instantiated and `inv` is honoured.
- **Undefined:**
  - No inverse logic is synthesised.
  - `inv` is ignored, and the sampled flag is forced to 0.
  - The port remains present so the interface does not change.

## Structure
- Package `aes_pkg` holds:
  - `typedef logic [127:0] aes_state_t` and `typedef logic [31:0] aes_col_t`.
  - Functions `gf_xtime` and `gf_mul(byte, const)` for constants 02, 03, 09, 0B, 0D, 0E.
  - The FSM state enum `mc_state_e`.
  - Localparam `AES_NB = 4`.
- Sub-module `mix_column_unit` is purely combinational: one 32-bit column, with `inv` and `bypass` inputs. It is instantiated COLS_PER_CYCLE times.
- The top level holds only the FSM, the counter, the working register and the group mux/demux.

## Test plan
- **Forward, C = 1, 2 and 4:** `in_data` = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5 -> `out_data` = 128'h046681e5_e0cb199a_48f8d37a_2806264c. `out_valid` rises exactly N cycles after capture.
- **Inverse** (`AES_MIX_COLUMNS_INV_EN` defined): `in_data` = 128'h046681e5_e0cb199a_48f8d37a_2806264c with `inv` = 1 -> 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5.
- **Fixed-point columns:** columns db135345, f20a225c, c6c6c6c6, 01010101 -> 8e4da1bc, 9fdc589d, c6c6c6c6, 01010101.
- **Bypass:** `bypass` = 1 and `inv` = 1 with any state -> `out_data` equals `in_data`, with the same latency as forward mode.
- **Backpressure:** hold `out_ready` = 0 for 10 cycles -> `out_data` is stable and `in_ready` = 0 throughout. Changing `inv` or `in_data` meanwhile has no effect. Raise `out_ready` -> IDLE next cycle.
- **Reset:** assert `rst` during BUSY with C=1 at g=2 -> next cycle `out_valid` = 0, `in_ready` = 1, `out_data` = 0. A following state processes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and the MixColumns engine state encoding.
package aes_pkg;

    localparam int AES_NB = 4;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiply by chained xtime; only the MixColumns coefficients are needed.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        case (c)
            8'h01:   return b;
            8'h02:   return x2;
            8'h03:   return x2 ^ b;
            8'h09:   return x8 ^ b;
            8'h0b:   return x8 ^ x2 ^ b;
            8'h0d:   return x8 ^ x4 ^ b;
            8'h0e:   return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns for one 32-bit column (row 0 in the top byte).
// Inverse matrix is only built when AES_MIX_COLUMNS_INV_EN is defined.
module mix_column_unit
    import aes_pkg::*;
(
    input  logic [31:0] col,
    input  logic        inv,
    input  logic        bypass,
    output logic [31:0] result
);

    logic [7:0] a0, a1, a2, a3;
    logic [31:0] fwd_col;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    assign fwd_col[31:24] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
    assign fwd_col[23:16] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
    assign fwd_col[15:8]  = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
    assign fwd_col[7:0]   = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);

`ifdef AES_MIX_COLUMNS_INV_EN
    logic [31:0] inv_col;

    assign inv_col[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign inv_col[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign inv_col[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign inv_col[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);

    // Bypass wins over inverse so the final round can pass data untouched.
    assign result = bypass ? col : (inv ? inv_col : fwd_col);
`else
    logic unused_inv;
    assign unused_inv = inv;

    assign result = bypass ? col : fwd_col;
`endif

endmodule

// File: rtl/mix_columns_engine.sv
// Handshaked MixColumns engine: COLS_PER_CYCLE column units walk the state in place.
// AES_MIX_COLUMNS_INV_EN enables InvMixColumns; otherwise the inv input is ignored.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         inv,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int NGRP = AES_NB / COLS_PER_CYCLE;

    localparam logic [1:0] ST_IDLE  = 2'(MC_IDLE);
    localparam logic [1:0] ST_BUSY  = 2'(MC_BUSY);
    localparam logic [1:0] ST_DONE  = 2'(MC_DONE);
    localparam logic [1:0] GRP_LAST = 2'(NGRP - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0]  state;
    logic [1:0]  grp;
    aes_state_t  work;
    logic        inv_q;
    logic        byp_q;
    logic        inv_sel;

    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

`ifdef AES_MIX_COLUMNS_INV_EN
    assign inv_sel = inv;
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign inv_sel    = 1'b0;
`endif

    // Group g covers columns 3-g*C down to 4-(g+1)*C, highest word first.
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_idx[k] = 2'(AES_NB - 1 - int'(grp) * COLS_PER_CYCLE - k);
            col_in[k]  = work[{col_idx[k], 5'b0} +: 32];
        end
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
        mix_column_unit u_mcu (
            .col    (col_in[k]),
            .inv    (inv_q),
            .bypass (byp_q),
            .result (col_out[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            grp   <= 2'd0;
            work  <= '0;
            inv_q <= 1'b0;
            byp_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work  <= in_data;
                        inv_q <= inv_sel;
                        byp_q <= bypass;
                        grp   <= 2'd0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                        work[{col_idx[k], 5'b0} +: 32] <= col_out[k];
                    end
                    if (grp == GRP_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        grp <= grp + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_data  = work;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (C=1,2,4) driven in lockstep,
// compared against a matrix-level GF(2^8) reference model.
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         inv;
    logic         bypass;
    logic         out_ready;

    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [127:0] od [3];

    int nvec = 0;
    int nerr = 0;
    int nlat [3];

    always #5 clk = ~clk;

    mix_columns_engine #(.COLS_PER_CYCLE(1)) dut_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .inv(inv), .bypass(bypass), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0])
    );
    mix_columns_engine #(.COLS_PER_CYCLE(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .inv(inv), .bypass(bypass), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1])
    );
    mix_columns_engine #(.COLS_PER_CYCLE(4)) dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .inv(inv), .bypass(bypass), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply, poly 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product: row r uses coefficient index (j - r) mod 4.
    function automatic logic [127:0] model(input logic [127:0] s, input logic i, input logic b);
        logic [7:0]   coef [4];
        logic [127:0] r;
        logic [7:0]   acc;
        logic         use_inv;
`ifdef AES_MIX_COLUMNS_INV_EN
        use_inv = i;
`else
        use_inv = 1'b0;
`endif
        if (b) return s;
        if (use_inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row + 4) % 4], s[c*32 + 24 - 8*j +: 8]);
                r[c*32 + 24 - 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (ir != 3'b111 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (ir != 3'b111) check({tag, "_idle_timeout"}, 128'(ir), 128'(3'b111));
    endtask

    task automatic run_txn(input string tag, input logic [127:0] din, input logic i, input logic b,
                           input logic [127:0] exp, input int hold);
        int lat [3];
        int bad [3];
        wait_idle(tag);
        in_data  = din;
        inv      = i;
        bypass   = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rnd128();
        inv      = ~i;
        bypass   = ~b;
        for (int k = 0; k < 3; k++) lat[k] = -1;
        for (int cyc = 1; cyc <= 10 && ov != 3'b111; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++)
                if (lat[k] < 0 && ov[k]) lat[k] = cyc;
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_lat_c%0d", tag, k), 128'(lat[k]), 128'(nlat[k]));
            check($sformatf("%s_data_c%0d", tag, k), od[k], exp);
            bad[k] = 0;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = rnd128();
            inv      = 1'($urandom);
            bypass   = 1'($urandom);
            for (int k = 0; k < 3; k++)
                if (od[k] !== exp || ov[k] !== 1'b1 || ir[k] !== 1'b0) bad[k]++;
        end
        if (hold > 0)
            for (int k = 0; k < 3; k++)
                check($sformatf("%s_hold_c%0d", tag, k), 128'(bad[k]), 128'(0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            check($sformatf("%s_ret_c%0d", tag, k), 128'({ir[k], ov[k]}), 128'(2'b10));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] d;
        logic         ri;
        logic         rb;
        nlat[0] = 4;
        nlat[1] = 2;
        nlat[2] = 1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        inv       = 1'b0;
        bypass    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_hs_c%0d", k), 128'({ir[k], ov[k]}), 128'(2'b10));
            check($sformatf("rst_data_c%0d", k), od[k], 128'h0);
        end

        run_txn("fwd", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0,
                128'h046681e5_e0cb199a_48f8d37a_2806264c, 0);
        run_txn("fixpt", 128'hdb135345_f20a225c_c6c6c6c6_01010101, 1'b0, 1'b0,
                128'h8e4da1bc_9fdc589d_c6c6c6c6_01010101, 0);
`ifdef AES_MIX_COLUMNS_INV_EN
        run_txn("inv", 128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b1, 1'b0,
                128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 0);
`else
        run_txn("inv_off", 128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b1, 1'b0,
                model(128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b0, 1'b0), 0);
`endif
        d = rnd128();
        run_txn("bypass", d, 1'b1, 1'b1, d, 0);
        d = rnd128();
        run_txn("bkpr", d, 1'b0, 1'b0, model(d, 1'b0, 1'b0), 10);

        // Reset while the C=1 instance is on group 2.
        wait_idle("rstmid");
        in_data  = rnd128();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rstmid_hs_c%0d", k), 128'({ir[k], ov[k]}), 128'(2'b10));
            check($sformatf("rstmid_data_c%0d", k), od[k], 128'h0);
        end
        d = rnd128();
        run_txn("post_rst", d, 1'b0, 1'b0, model(d, 1'b0, 1'b0), 0);

        for (int t = 0; t < 24; t++) begin
            d  = rnd128();
            ri = 1'($urandom);
            rb = ($urandom_range(0, 3) == 0);
            run_txn($sformatf("rnd%0d", t), d, ri, rb, model(d, ri, rb), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
